// File: rtl/wb_arb_pkg.sv
// Shared definitions for the two-master Wishbone arbiter: FSM encoding,
// master indices and counter width.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_GNT_PIX = 2'b01,
        ST_GNT_CPU = 2'b10,
        ST_RELEASE = 2'b11
    } arb_state_t;

    localparam int unsigned PIX   = 0;
    localparam int unsigned CPU   = 1;
    localparam int unsigned CNT_W = 8;

endpackage

// File: rtl/wb_timeout.sv
// Slave-ack watchdog: counts granted cycles without an ack and flags expiry
// on the cycle the count reaches the limit.
module wb_timeout
    import wb_arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] limit,
    output logic             expire
);

    logic [CNT_W-1:0] count;

    // count holds (granted cycles - 1), so expiry lands on the limit-th cycle;
    // a clear on the same cycle (slave ack) always wins.
    assign expire = en && !clr && (count == limit - 8'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 8'd1;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Two-master Wishbone arbiter: pixel fetch (m0, read-only) normally wins,
// CPU (m1) takes priority once it has starved for STARVE_LIMIT cycles.
module wb_arbiter
    import wb_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT      = 255,
    parameter int unsigned STARVE_LIMIT = 15
) (
    input  logic        i_wb_clk,
    input  logic        i_wb_rst,
    input  logic [31:0] i_m0_addr,
    input  logic        i_m0_cyc,
    output logic        o_m0_ack,
    output logic        o_m0_err,
    input  logic [31:0] i_m1_addr,
    input  logic        i_m1_cyc,
    input  logic        i_m1_we,
    input  logic [31:0] i_m1_dat,
    output logic        o_m1_ack,
    output logic        o_m1_err,
    output logic [31:0] o_m_dat,
    output logic [31:0] o_wb_addr,
    output logic        o_wb_cyc,
    output logic        o_wb_we,
    output logic [31:0] o_wb_dat,
    input  logic        i_wb_ack,
    input  logic [31:0] i_wb_dat
);

    localparam logic [CNT_W-1:0] TMO_LIM    = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_LIMIT);

    arb_state_t       state, state_nxt;
    logic             rst_sync;
    logic [1:0]       lock;
    logic [CNT_W-1:0] starve_cnt;
    logic             m0_req, m1_req, cpu_starved;
    logic             gnt_pix, gnt_cpu, gnt_cyc, grant_entry, cpu_entry;
    logic             tmo_clr, tmo_en, tmo_expire;

    // Reset release is taken one edge late so no grant can start on the
    // edge that first sees the deassertion.
    always_ff @(posedge i_wb_clk or negedge i_wb_rst) begin
        if (!i_wb_rst) rst_sync <= 1'b0;
        else           rst_sync <= 1'b1;
    end

    assign m0_req      = i_m0_cyc & ~lock[PIX];
    assign m1_req      = i_m1_cyc & ~lock[CPU];
    assign cpu_starved = m1_req && (starve_cnt >= STARVE_LIM);
    assign gnt_pix     = (state == ST_GNT_PIX);
    assign gnt_cpu     = (state == ST_GNT_CPU);
    assign gnt_cyc     = (gnt_pix & i_m0_cyc) | (gnt_cpu & i_m1_cyc);
    assign grant_entry = (state == ST_IDLE) && (state_nxt != ST_IDLE);
    assign cpu_entry   = !gnt_cpu && (state_nxt == ST_GNT_CPU);

    assign tmo_clr = grant_entry | ((gnt_pix | gnt_cpu) & i_wb_ack);
    assign tmo_en  = gnt_cyc;

    wb_timeout u_timeout (
        .clk    (i_wb_clk),
        .rst_n  (i_wb_rst),
        .clr    (tmo_clr),
        .en     (tmo_en),
        .limit  (TMO_LIM),
        .expire (tmo_expire)
    );

    always_ff @(posedge i_wb_clk or negedge i_wb_rst) begin
        if (!i_wb_rst) state <= ST_IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (rst_sync) begin
                    if (m0_req && !cpu_starved) state_nxt = ST_GNT_PIX;
                    else if (m1_req)            state_nxt = ST_GNT_CPU;
                end
            end
            ST_GNT_PIX, ST_GNT_CPU: begin
                if (!gnt_cyc || tmo_expire) state_nxt = ST_RELEASE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // An aborted master stays locked out until it drops cyc for a cycle.
    always_ff @(posedge i_wb_clk or negedge i_wb_rst) begin
        if (!i_wb_rst) begin
            lock <= '0;
        end else begin
            if (gnt_pix && tmo_expire) lock[PIX] <= 1'b1;
            else if (!i_m0_cyc)        lock[PIX] <= 1'b0;
            if (gnt_cpu && tmo_expire) lock[CPU] <= 1'b1;
            else if (!i_m1_cyc)        lock[CPU] <= 1'b0;
        end
    end

    always_ff @(posedge i_wb_clk or negedge i_wb_rst) begin
        if (!i_wb_rst) begin
            starve_cnt <= '0;
        end else if (!i_m1_cyc || cpu_entry) begin
            starve_cnt <= '0;
        end else if (!gnt_cpu && (starve_cnt != '1)) begin
            starve_cnt <= starve_cnt + 8'd1;
        end
    end

    always_comb begin
        o_wb_addr = '0;
        o_wb_cyc  = 1'b0;
        o_wb_we   = 1'b0;
        o_wb_dat  = '0;
        o_m0_ack  = 1'b0;
        o_m1_ack  = 1'b0;
        o_m0_err  = 1'b0;
        o_m1_err  = 1'b0;
        case (state)
            ST_GNT_PIX: begin
                o_wb_addr = i_m0_addr;
                o_wb_cyc  = i_m0_cyc;
                o_m0_ack  = i_wb_ack;
                o_m0_err  = tmo_expire;
            end
            ST_GNT_CPU: begin
                o_wb_addr = i_m1_addr;
                o_wb_cyc  = i_m1_cyc;
                o_wb_we   = i_m1_we;
                o_wb_dat  = i_m1_dat;
                o_m1_ack  = i_wb_ack;
                o_m1_err  = tmo_expire;
            end
            default: ;
        endcase
    end

    assign o_m_dat = i_wb_dat;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: a per-cycle vector table plus hand-written
// sequences for starvation, timeout, lockout and asynchronous reset.
module tb_wb_arbiter;

    localparam logic [31:0] A0 = 32'h1000_0000;
    localparam logic [31:0] A1 = 32'h2000_0004;
    localparam logic [31:0] D1 = 32'hCAFE_F00D;
    localparam logic [31:0] DS = 32'h5A5A_0001;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] m0_addr = A0, m1_addr = A1, m1_dat = D1, wb_dat_in = DS;
    logic        m0_cyc = 1'b0, m1_cyc = 1'b0, m1_we = 1'b0, wb_ack = 1'b0;
    logic        m0_ack, m0_err, m1_ack, m1_err, wb_cyc, wb_we;
    logic [31:0] m_dat, wb_addr, wb_dat;

    int n_tests = 0;
    int n_fail  = 0;

    wb_arbiter #(.TIMEOUT(8), .STARVE_LIMIT(15)) dut (
        .i_wb_clk  (clk),
        .i_wb_rst  (rst),
        .i_m0_addr (m0_addr),
        .i_m0_cyc  (m0_cyc),
        .o_m0_ack  (m0_ack),
        .o_m0_err  (m0_err),
        .i_m1_addr (m1_addr),
        .i_m1_cyc  (m1_cyc),
        .i_m1_we   (m1_we),
        .i_m1_dat  (m1_dat),
        .o_m1_ack  (m1_ack),
        .o_m1_err  (m1_err),
        .o_m_dat   (m_dat),
        .o_wb_addr (wb_addr),
        .o_wb_cyc  (wb_cyc),
        .o_wb_we   (wb_we),
        .o_wb_dat  (wb_dat),
        .i_wb_ack  (wb_ack),
        .i_wb_dat  (wb_dat_in)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    typedef struct {
        logic        m0, m1, we, ack;
        logic        cyc, wwe, a0, a1, e0, e1;
        logic [31:0] addr, dat;
    } vec_t;

    function automatic logic [95:0] pk(input logic cyc, input logic we, input logic a0,
                                       input logic a1, input logic e0, input logic e1,
                                       input logic [31:0] addr, input logic [31:0] dat);
        return {26'b0, cyc, we, a0, a1, e0, e1, addr, dat};
    endfunction

    function automatic vec_t mk(input logic m0, input logic m1, input logic we, input logic ack,
                                input logic cyc, input logic wwe, input logic [31:0] addr,
                                input logic [31:0] dat, input logic a0, input logic a1);
        vec_t v;
        v.m0 = m0; v.m1 = m1; v.we = we; v.ack = ack;
        v.cyc = cyc; v.wwe = wwe; v.addr = addr; v.dat = dat;
        v.a0 = a0; v.a1 = a1; v.e0 = 1'b0; v.e1 = 1'b0;
        return v;
    endfunction

    function automatic logic [95:0] obs();
        return pk(wb_cyc, wb_we, m0_ack, m1_ack, m0_err, m1_err, wb_addr, wb_dat);
    endfunction

    task automatic check(input string name, input logic [95:0] got, input logic [95:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    vec_t        tbl[23];
    logic [95:0] ZERO;
    int          r;

    initial begin
        ZERO = pk(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        //            m0 m1 we ack  cyc we addr   dat     a0 a1
        tbl[0]  = mk(1, 0, 0, 0,   0, 0, 32'h0, 32'h0, 0, 0);
        tbl[1]  = mk(1, 0, 0, 0,   0, 0, 32'h0, 32'h0, 0, 0);
        tbl[2]  = mk(1, 0, 0, 0,   1, 0, A0,    32'h0, 0, 0);
        tbl[3]  = mk(1, 0, 0, 1,   1, 0, A0,    32'h0, 1, 0);
        tbl[4]  = mk(1, 0, 0, 1,   1, 0, A0,    32'h0, 1, 0);
        tbl[5]  = mk(1, 0, 0, 1,   1, 0, A0,    32'h0, 1, 0);
        tbl[6]  = mk(1, 0, 0, 1,   1, 0, A0,    32'h0, 1, 0);
        tbl[7]  = mk(0, 0, 0, 0,   0, 0, A0,    32'h0, 0, 0);
        tbl[8]  = mk(0, 0, 0, 0,   0, 0, 32'h0, 32'h0, 0, 0);
        tbl[9]  = mk(0, 1, 1, 0,   0, 0, 32'h0, 32'h0, 0, 0);
        tbl[10] = mk(0, 1, 1, 0,   1, 1, A1,    D1,    0, 0);
        tbl[11] = mk(0, 1, 1, 1,   1, 1, A1,    D1,    0, 1);
        tbl[12] = mk(1, 0, 1, 0,   0, 1, A1,    D1,    0, 0);
        tbl[13] = mk(1, 0, 0, 0,   0, 0, 32'h0, 32'h0, 0, 0);
        tbl[14] = mk(1, 0, 0, 0,   0, 0, 32'h0, 32'h0, 0, 0);
        tbl[15] = mk(1, 1, 0, 1,   1, 0, A0,    32'h0, 1, 0);
        tbl[16] = mk(0, 1, 0, 0,   0, 0, A0,    32'h0, 0, 0);
        tbl[17] = mk(0, 1, 0, 0,   0, 0, 32'h0, 32'h0, 0, 0);
        tbl[18] = mk(0, 1, 0, 0,   0, 0, 32'h0, 32'h0, 0, 0);
        tbl[19] = mk(0, 1, 0, 1,   1, 0, A1,    D1,    0, 1);
        tbl[20] = mk(0, 0, 0, 0,   0, 0, A1,    D1,    0, 0);
        tbl[21] = mk(0, 0, 0, 0,   0, 0, 32'h0, 32'h0, 0, 0);
        tbl[22] = mk(0, 0, 0, 0,   0, 0, 32'h0, 32'h0, 0, 0);

        // Reset held: outputs quiet even with a request and clock edges.
        m0_cyc = 1'b1;
        step(); step();
        check("reset_state", obs(), ZERO);
        check("m_dat_pass", {64'h0, m_dat}, {64'h0, DS});
        wb_dat_in = 32'h0123_4567;
        #1;
        check("m_dat_unreg", {64'h0, m_dat}, {64'h0, 32'h0123_4567});
        wb_dat_in = DS;

        rst = 1'b1;
        for (int i = 0; i < 23; i++) begin
            m0_cyc = tbl[i].m0; m1_cyc = tbl[i].m1; m1_we = tbl[i].we; wb_ack = tbl[i].ack;
            #1;
            check($sformatf("vec%0d", i), obs(),
                  pk(tbl[i].cyc, tbl[i].wwe, tbl[i].a0, tbl[i].a1, tbl[i].e0, tbl[i].e1,
                     tbl[i].addr, tbl[i].dat));
            step();
        end

        // Simultaneous requests: pixel first, CPU after pixel's 20-cycle burst.
        m0_cyc = 1'b1; m1_cyc = 1'b1; m1_we = 1'b0; wb_ack = 1'b0;
        #1; check("both_idle", obs(), ZERO);
        step();
        for (int i = 0; i < 20; i++) begin
            wb_ack = 1'b1;
            #1; check($sformatf("pix_hold%0d", i), obs(), pk(1, 0, 1, 0, 0, 0, A0, 32'h0));
            step();
        end
        m0_cyc = 1'b0; wb_ack = 1'b0;
        #1; check("pix_drop", obs(), pk(0, 0, 0, 0, 0, 0, A0, 32'h0));
        step(); check("pix_release", obs(), ZERO);
        step(); check("idle_before_cpu", obs(), ZERO);
        step(); check("cpu_after_pix", obs(), pk(1, 0, 0, 0, 0, 0, A1, D1));
        check("starve_zero_on_grant", {88'h0, dut.starve_cnt}, 96'h0);
        m1_cyc = 1'b0;
        step(); step();

        // Back-to-back pixel bursts with CPU waiting: CPU wins at cycle 16.
        for (int c = 0; c <= 16; c++) begin
            r = c % 5;
            m1_cyc = 1'b1;
            m0_cyc = !(r == 3);
            wb_ack = (c < 15) && (r == 1 || r == 2);
            #1;
            if (c == 16)                          check($sformatf("starve_c%0d", c), obs(), pk(1, 0, 0, 0, 0, 0, A1, D1));
            else if (c < 15 && (r == 1 || r == 2)) check($sformatf("starve_c%0d", c), obs(), pk(1, 0, 1, 0, 0, 0, A0, 32'h0));
            else if (c < 15 && r == 3)             check($sformatf("starve_c%0d", c), obs(), pk(0, 0, 0, 0, 0, 0, A0, 32'h0));
            else                                   check($sformatf("starve_c%0d", c), obs(), ZERO);
            step();
        end
        m0_cyc = 1'b0; m1_cyc = 1'b0; wb_ack = 1'b0;
        step(); step();

        // Timeout on CPU: err on the 8th grant cycle, then lockout while cyc held.
        m1_cyc = 1'b1;
        #1; check("tmo_idle", obs(), ZERO);
        step();
        for (int k = 1; k <= 8; k++) begin
            #1; check($sformatf("tmo_k%0d", k), obs(), pk(1, 0, 0, 0, 0, k == 8, A1, D1));
            step();
        end
        for (int j = 0; j < 4; j++) begin
            #1; check($sformatf("tmo_lock%0d", j), obs(), ZERO);
            step();
        end
        m1_cyc = 1'b0;
        #1; check("tmo_drop", obs(), ZERO);
        step();
        m1_cyc = 1'b1;
        #1; check("tmo_rearb_idle", obs(), ZERO);
        step();
        // Ack coincident with the expiry cycle wins and the transfer continues.
        for (int k = 1; k <= 9; k++) begin
            wb_ack = (k == 8);
            #1; check($sformatf("ackwin_k%0d", k), obs(), pk(1, 0, 0, k == 8, 0, 0, A1, D1));
            step();
        end
        wb_ack = 1'b0; m1_cyc = 1'b0;
        #1; check("ackwin_drop", obs(), pk(0, 0, 0, 0, 0, 0, A1, D1));
        step(); step();

        // Request pulse inside one cycle in IDLE never produces a grant.
        m0_cyc = 1'b1;
        #3; m0_cyc = 1'b0;
        #1; check("pulse_nogrant0", obs(), ZERO);
        step(); check("pulse_nogrant1", obs(), ZERO);
        step(); check("pulse_nogrant2", obs(), ZERO);

        // Asynchronous reset mid-burst, then restart from IDLE.
        m0_cyc = 1'b1;
        step();
        wb_ack = 1'b1;
        #1; check("burst_pre_reset", obs(), pk(1, 0, 1, 0, 0, 0, A0, 32'h0));
        #1; rst = 1'b0;
        #1; check("async_reset", obs(), ZERO);
        #1; rst = 1'b1;
        #1; check("reset_released", obs(), ZERO);
        step(); check("first_edge_after_rst", obs(), ZERO);
        step(); check("regrant_after_rst", obs(), pk(1, 0, 1, 0, 0, 0, A0, 32'h0));
        m0_cyc = 1'b0; wb_ack = 1'b0;
        step(); step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
